led_strip_driver: RTL

LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

---
 rtl/led_strip_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/led_strip_driver.sv
// Single-wire addressable LED strip driver: streams MAX_POS GRB pixels as
// pulse-width coded bits, MSB first, then holds the line low for the latch gap.
module led_strip_driver #(
    parameter int MAX_POS = 109,
    parameter int T0H     = 17,
    parameter int T1H     = 35,
    parameter int T_BIT   = 63,
    parameter int T_LATCH = 3000,
    localparam int IDX_W  = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refresh,
    input  logic [7:0]       led_green_intensity,
    input  logic [7:0]       led_red_intensity,
    input  logic [7:0]       led_blue_intensity,
    output logic [IDX_W-1:0] current_led,
    output logic             data_out,
    output logic             busy,
    output logic             frame_done,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int BW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;

    localparam logic [BW-1:0]    BIT_LAST = BW'(T_BIT - 1);
    localparam logic [BW-1:0]    T0H_C    = BW'(T0H);
    localparam logic [BW-1:0]    T1H_C    = BW'(T1H);
    localparam logic [LW-1:0]    LAT_LAST = LW'(T_LATCH - 1);
    localparam logic [LW-1:0]    LAT_PRE  = LW'(T_LATCH - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_POS - 1);
    localparam logic [4:0]       BIT_IDX_LAST = 5'd23;

    state_t           state_q;
    logic [23:0]      shift_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [4:0]       bit_idx_q;
    logic [LW-1:0]    lat_cnt_q;
    logic [IDX_W-1:0] led_q;
    logic             data_q;
    logic             busy_q;
    logic             done_q;

    logic [BW-1:0]    bit_cnt_d;
    logic [BW-1:0]    hi_len;
    logic [IDX_W-1:0] led_d;
    logic [23:0]      pixel;

    assign bit_cnt_d = bit_cnt_q + 1'b1;
    assign hi_len    = shift_q[23] ? T1H_C : T0H_C;
    // The pixel index doubles as the "pixels remaining" counter: it wraps to
    // zero exactly when the last pixel has been loaded.
    assign led_d     = (led_q == IDX_LAST) ? '0 : led_q + 1'b1;
    assign pixel     = {led_green_intensity, led_red_intensity, led_blue_intensity};

    // Outputs are registered, so each branch writes the value data_out must
    // carry in the following cycle; every bit starts high since T0H > 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            lat_cnt_q <= '0;
            led_q     <= '0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (refresh) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_q   <= pixel;
                    led_q     <= led_d;
                    bit_cnt_q <= '0;
                    bit_idx_q <= '0;
                    data_q    <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (bit_cnt_q != BIT_LAST) begin
                        bit_cnt_q <= bit_cnt_d;
                        data_q    <= (bit_cnt_d < hi_len);
                    end else begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q != BIT_IDX_LAST) begin
                            shift_q   <= {shift_q[22:0], 1'b0};
                            bit_idx_q <= bit_idx_q + 5'd1;
                            data_q    <= 1'b1;
                        end else if (led_q != '0) begin
                            shift_q   <= pixel;
                            led_q     <= led_d;
                            bit_idx_q <= '0;
                            data_q    <= 1'b1;
                        end else begin
                            state_q   <= LATCH;
                            lat_cnt_q <= '0;
                            data_q    <= 1'b0;
                            done_q    <= (T_LATCH == 1);
                        end
                    end
                end
                LATCH: begin
                    if (lat_cnt_q != LAT_LAST) begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                        done_q    <= (lat_cnt_q == LAT_PRE);
                    end else if (refresh) begin
                        // Held refresh chains straight into the next frame.
                        lat_cnt_q <= '0;
                        state_q   <= LOAD;
                    end else begin
                        lat_cnt_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign current_led = led_q;
    assign data_out    = data_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign dbg_state_o = state_q;

endmodule
